// File: rtl/pwm_dac_if.sv
// Sample/mute bus from the chiptune core to the PWM output stage, plus the
// monitor outputs the stage drives back.
interface pwm_dac_if #(
   parameter int WIDTH = 5
);
   logic signed [WIDTH-1:0] sample;
   logic                    mute;
   logic                    pwm_out;
   logic                    frame_start;
   logic [WIDTH-1:0]        level;
   logic                    ramp_busy;

   modport master (
      output sample,
      output mute,
      input  pwm_out,
      input  frame_start,
      input  level,
      input  ramp_busy
   );

   modport slave (
      input  sample,
      input  mute,
      output pwm_out,
      output frame_start,
      output level,
      output ramp_busy
   );
endinterface

// File: rtl/pwm_dac.sv
// Signed sample to 1-bit PWM, one frame per 2**WIDTH clocks, with a per-frame
// 1-LSB level ramp to silence pops at power-up, mute and unmute.
module pwm_dac #(
   parameter int WIDTH = 5
) (
   input logic    clk,
   input logic    rst_n,
   pwm_dac_if.slave bus
);
   typedef enum logic [1:0] {MUTED, RAMP_UP, RUN, RAMP_DOWN} state_t;

   localparam logic [WIDTH-1:0] MID = WIDTH'(1) << (WIDTH - 1);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] level;
   logic             ramp_busy;
   logic             boundary;
   logic [WIDTH-1:0] level_up;
   logic [WIDTH-1:0] level_dn;
   logic [WIDTH-1:0] target;

   // Two's complement to offset binary: flipping the MSB maps -16..15 onto 0..31.
   function automatic logic [WIDTH-1:0] to_offset(input logic signed [WIDTH-1:0] s);
      logic [WIDTH-1:0] u;
      u = s;
      u[WIDTH-1] = ~u[WIDTH-1];
      return u;
   endfunction

   always_comb begin
      boundary = (cnt == '1);
      level_up = level + ONE;
      level_dn = level - ONE;
      target   = to_offset(bus.sample);
   end

   // Frame counter and level/state update; inputs only matter on the boundary cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt       <= '1;
         level     <= '0;
         state     <= MUTED;
         ramp_busy <= 1'b0;
      end else begin
         cnt <= cnt + ONE;
         if (boundary) begin
            case (state)
               MUTED: begin
                  level <= '0;
                  if (!bus.mute) begin
                     state     <= RAMP_UP;
                     ramp_busy <= 1'b1;
                  end else begin
                     ramp_busy <= 1'b0;
                  end
               end
               RAMP_UP: begin
                  if (bus.mute) begin
                     state     <= RAMP_DOWN;
                     ramp_busy <= 1'b1;
                  end else begin
                     level <= level_up;
                     if (level_up == MID) begin
                        state     <= RUN;
                        ramp_busy <= 1'b0;
                     end else begin
                        ramp_busy <= 1'b1;
                     end
                  end
               end
               RUN: begin
                  if (bus.mute) begin
                     state     <= RAMP_DOWN;
                     ramp_busy <= 1'b1;
                  end else begin
                     level     <= target;
                     ramp_busy <= 1'b0;
                  end
               end
               RAMP_DOWN: begin
                  // An unmute here is ignored; the ramp always lands in MUTED first.
                  if (level == '0 || level == ONE) begin
                     level     <= '0;
                     state     <= MUTED;
                     ramp_busy <= 1'b0;
                  end else begin
                     level     <= level_dn;
                     ramp_busy <= 1'b1;
                  end
               end
               default: begin
                  level     <= '0;
                  state     <= MUTED;
                  ramp_busy <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.pwm_out     = (cnt < level);
   assign bus.frame_start = (cnt == '0);
   assign bus.level       = level;
   assign bus.ramp_busy   = ramp_busy;
endmodule

// File: tb/tb_pwm_dac.sv
// Directed bench for pwm_dac: measures the duty of whole frames against
// hand-computed expectations for ramp, run, mute and reset scenarios.
module tb_pwm_dac;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   pwm_dac_if #(.WIDTH(5)) bus ();

   pwm_dac #(.WIDTH(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Runs one 32-clock frame starting at its cnt==0 cycle. Inputs for the next
   // boundary are driven on each falling edge; outputs are sampled there too.
   task automatic run_frame(input logic signed [4:0] smp, input logic mte, input logic tog,
                            input int mpulse, output int highs, output int starts,
                            output int lv0, output int busy0);
      highs  = 0;
      starts = 0;
      lv0    = 0;
      busy0  = 0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         highs  += int'(bus.pwm_out);
         starts += int'(bus.frame_start);
         if (i == 0) begin
            lv0   = int'(bus.level);
            busy0 = int'(bus.ramp_busy);
         end
         if (tog && i != 31) bus.sample = (i % 2 == 1) ? 5'sd15 : -5'sd16;
         else                bus.sample = smp;
         bus.mute = (i == mpulse) ? 1'b1 : mte;
      end
   endtask

   task automatic check_frame(input string tag, input logic signed [4:0] smp, input logic mte,
                              input logic tog, input int mpulse, input int exp_high,
                              input int exp_busy);
      int h, s, lv, b;
      run_frame(smp, mte, tog, mpulse, h, s, lv, b);
      check({tag, "_high"}, h, exp_high);
      check({tag, "_level"}, lv, exp_high);
      check({tag, "_busy"}, b, exp_busy);
      check({tag, "_fstart"}, s, 1);
   endtask

   initial begin
      rst_n      = 1'b0;
      bus.sample = 5'sd0;
      bus.mute   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_pwm", int'(bus.pwm_out), 0);
      check("rst_level", int'(bus.level), 0);
      check("rst_fstart", int'(bus.frame_start), 0);
      check("rst_busy", int'(bus.ramp_busy), 0);
      rst_n = 1'b1;

      // Power-up ramp: frame k carries k high clocks
      for (int k = 0; k <= 16; k++)
         check_frame($sformatf("t1_f%0d", k), 5'sd0, 1'b0, 1'b0, -1, k, (k < 16) ? 1 : 0);

      // Run: extremes and -1
      check_frame("t2_a", 5'sd15, 1'b0, 1'b0, -1, 16, 0);
      check_frame("t2_b", -5'sd16, 1'b0, 1'b0, -1, 31, 0);
      check_frame("t2_c", -5'sd1, 1'b0, 1'b0, -1, 0, 0);
      check_frame("t2_d", 5'sd4, 1'b0, 1'b0, -1, 15, 0);

      // Mid-frame mute pulse ignored, then held mute ramps 20 down to 0
      check_frame("t3_pulse", 5'sd4, 1'b0, 1'b0, 12, 20, 0);
      check_frame("t3_hold", 5'sd4, 1'b1, 1'b0, -1, 20, 0);
      for (int j = 20; j >= 0; j--)
         check_frame($sformatf("t3_dn%0d", j), 5'sd4, 1'b1, 1'b0, -1, j, (j != 0) ? 1 : 0);
      check_frame("t3_muted", 5'sd4, 1'b1, 1'b0, -1, 0, 0);

      // Unmute, mute at level 5, unmute mid ramp-down
      check_frame("t4_unm", 5'sd0, 1'b0, 1'b0, -1, 0, 0);
      for (int k = 0; k <= 4; k++)
         check_frame($sformatf("t4_up%0d", k), 5'sd0, 1'b0, 1'b0, -1, k, 1);
      check_frame("t4_m5a", 5'sd0, 1'b1, 1'b0, -1, 5, 1);
      check_frame("t4_m5b", 5'sd0, 1'b1, 1'b0, -1, 5, 1);
      check_frame("t4_m4", 5'sd0, 1'b1, 1'b0, -1, 4, 1);
      check_frame("t4_u3", 5'sd0, 1'b0, 1'b0, -1, 3, 1);
      check_frame("t4_u2", 5'sd0, 1'b0, 1'b0, -1, 2, 1);
      check_frame("t4_u1", 5'sd0, 1'b0, 1'b0, -1, 1, 1);
      check_frame("t4_u0", 5'sd0, 1'b0, 1'b0, -1, 0, 0);
      check_frame("t4_r0", 5'sd0, 1'b0, 1'b0, -1, 0, 1);
      for (int k = 1; k <= 15; k++)
         check_frame($sformatf("t4_r%0d", k), 5'sd0, 1'b0, 1'b0, -1, k, 1);

      // Sample toggling every clock: only the cnt==31 value counts
      check_frame("t5_tog_a", 5'sd7, 1'b0, 1'b1, -1, 16, 0);
      check_frame("t5_tog_b", -5'sd8, 1'b0, 1'b1, -1, 23, 0);
      check_frame("t5_c", 5'sd8, 1'b0, 1'b0, -1, 8, 0);
      check_frame("t6_pre", 5'sd8, 1'b0, 1'b0, -1, 24, 0);

      // Reset mid-frame at level 24
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 5) check("t6_mid_pwm", int'(bus.pwm_out), 1);
      end
      rst_n = 1'b0;
      @(negedge clk);
      check("t6_rst_pwm", int'(bus.pwm_out), 0);
      check("t6_rst_level", int'(bus.level), 0);
      check("t6_rst_fstart", int'(bus.frame_start), 0);
      check("t6_rst_busy", int'(bus.ramp_busy), 0);
      rst_n = 1'b1;
      for (int k = 0; k <= 2; k++)
         check_frame($sformatf("t6_f%0d", k), 5'sd8, 1'b0, 1'b0, -1, k, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
